centroid_smoother: RTL
======================

// Module: centroid_smoother
// PURPOSE
//  Downstream of the centre-of-mass stage: takes one centroid per frame (x_in/y_in/valid_in).
//  Emits a moving average of the last 2**DEPTH_LOG2 centroids to the wall-matching/overlay logic.
//  Declares the target lost after TIMEOUT_FRAMES consecutive frames with no centroid.
// PARAMETERS
//  DEPTH_LOG2      2  log2 of averaging window (window = 4 samples); range 1..4
//  TIMEOUT_FRAMES  8  consecutive empty frames before LOST; range 1..255
// PORTS
//  clk_in         in   1   system clock, sole clock domain
//  rst_n_in       in   1   reset, asynchronous, active-low
//  x_in           in   11  centroid x, 0..1023
//  y_in           in   10  centroid y, 0..767
//  valid_in       in   1   one-cycle strobe, x_in/y_in valid
//  frame_done_in  in   1   one-cycle strobe at end of each frame
//  x_out          out  11  smoothed x
//  y_out          out  10  smoothed y
//  valid_out      out  1   one-cycle strobe, x_out/y_out updated
//  locked_out     out  1   level: window full, target tracked
//  lost_out       out  1   level: timeout expired, no target
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - x_out=0, y_out=0, valid_out=0, locked_out=0, lost_out=0
//   - sums=0, count=0, wr_ptr=0, miss_cnt=0, state=EMPTY
//  States:
//   - EMPTY  -> FILLING on valid_in
//   - FILLING -> LOCKED when count reaches DEPTH
//   - LOCKED stays LOCKED on valid_in
//   - EMPTY/FILLING/LOCKED -> LOST when miss_cnt reaches TIMEOUT_FRAMES
//   - LOST -> FILLING on valid_in
//  Sample path, fixed 2-cycle pipeline, one sample/cycle, no back-pressure:
//   - C1: write sample at wr_ptr (wraps DEPTH-1 -> 0).
//   - C1: sum_x += x_in - evicted_x (evicted=0 while count<DEPTH); y likewise.
//   - C1: count saturates at DEPTH.
//   - C2: x_out = sum_x >> DEPTH_LOG2 when count==DEPTH, else x_out = newest sample (no divide).
//   - C2: y_out likewise. valid_out pulses exactly 2 cycles after valid_in.
//  Widths: sum_x is 11+DEPTH_LOG2 bits, sum_y is 10+DEPTH_LOG2 bits. No overflow possible; truncating shift.
//  Timeout:
//   - frame_done_in with no valid_in since previous frame_done_in: miss_cnt++ (saturating).
//   - any valid_in clears miss_cnt.
//   - Entering LOST: count=0, sums=0, wr_ptr=0; x_out/y_out hold last value; no valid_out.
//  locked_out=1 only in LOCKED. lost_out=1 only in LOST.
//  valid_in and frame_done_in in the same cycle: sample accepted; the frame counts as a hit, miss_cnt=0.
//  Reset mid-pipeline: in-flight sample discarded; no valid_out after reset release.
// CONFIGURATION
//  CENTROID_DEADBAND_EN defined:
//   - in C2, if |avg-x_out|<=DEADBAND and |avg-y_out|<=DEADBAND, x_out/y_out hold their values.
//   - valid_out still pulses; buffer and sums still update.
//  CENTROID_DEADBAND_EN undefined: outputs always take the new value.
// STRUCTURE
//  centroid_pkg:
//   - coord_x_t logic[10:0], coord_y_t logic[9:0]
//   - smooth_state_t enum {EMPTY, FILLING, LOCKED, LOST}
//   - DEADBAND localparam = 2
//  Sub-module centroid_ring_buffer:
//   - DEPTH-entry storage; write pointer; wrap handling.
//   - returns the evicted entry combinationally; synchronous clear.
//  Top level holds the FSM, sums, timeout counter and output stage.
// TESTING
//  1 Reset: hold rst_n_in low, drive valid_in -> all outputs 0, state EMPTY, no valid_out.
//  2 Fill, DEPTH_LOG2=2:
//    - in: (100,50),(104,54),(108,58),(112,62)
//    - out: 100,104,108 passthrough, then (106,56); locked_out=1 after 4th; valid_out 2 cycles after each input.
//  3 Wrap: continue with (200,150) -> evicts (100,50); out (131,81), sums exact over 12 samples.
//  4 Timeout, TIMEOUT_FRAMES=8:
//    - 8 frame_done_in pulses without valid_in -> lost_out=1, locked_out=0, outputs held.
//    - next (300,300) -> out (300,300) passthrough, state FILLING.
//  5 Coincident valid_in+frame_done_in at miss_cnt=7 -> no LOST, miss_cnt=0.
//  6 Async reset asserted 1 cycle after valid_in -> no valid_out; sums 0 after release.
//  +DEADBAND_EN: locked at (106,56), then a sample moving avg to (107,57) -> out held at (106,56), valid_out=1.

Source files
------------

// File: rtl/centroid_pkg.sv
// Shared types and constants for the centroid smoothing path.
// Coordinates are 1024x768, with one sample record holding both axes.
package centroid_pkg;

    typedef logic [10:0] coord_x_t;
    typedef logic [9:0]  coord_y_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        LOCKED,
        LOST
    } smooth_state_t;

    typedef struct packed {
        coord_x_t x;
        coord_y_t y;
    } sample_t;

    localparam int DEADBAND = 2;

endpackage

// File: rtl/centroid_ring_buffer.sv
// Averaging-window storage. One write per cycle; the evicted entry is available combinationally, no backpressure.
// Writes land at wr_ptr; clr_i zeroes every entry and the pointer in a single cycle.
module centroid_ring_buffer
    import centroid_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic    clk_in,
    input  logic    rst_n_in,
    input  logic    wr_en_i,
    input  sample_t wr_dat_i,
    input  logic    clr_i,
    output sample_t evict_dat_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    sample_t               mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;

    // DEPTH is a power of two, so the pointer wraps DEPTH-1 -> 0 by overflow.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
    end

    assign evict_dat_o = mem_q[wr_ptr_q];

endmodule

// File: rtl/centroid_smoother.sv
// Moving average of the last 2**DEPTH_LOG2 centroids. Fixed 2-cycle latency, no backpressure; target declared lost after TIMEOUT_FRAMES empty frames.
// The optional CENTROID_DEADBAND_EN build holds the outputs while the new value stays within DEADBAND on both axes.
module centroid_smoother
    import centroid_pkg::*;
#(
    parameter int DEPTH_LOG2     = 2,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        frame_done_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        locked_out,
    output logic        lost_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SXW   = 11 + DEPTH_LOG2;
    localparam int SYW   = 10 + DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT_FRAMES);

    smooth_state_t  state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [SXW-1:0] sum_x_q, sum_x_d;
    logic [SYW-1:0] sum_y_q, sum_y_d;
    logic [7:0]     miss_q, miss_d;
    logic           seen_q, seen_d;
    logic           go_lost;

    logic           p1_vld_q;
    coord_x_t       p1_x_q;
    coord_y_t       p1_y_q;

    coord_x_t       x_out_q, x_out_d;
    coord_y_t       y_out_q, y_out_d;
    logic           valid_out_q;

    sample_t        evict;
    coord_x_t       ev_x;
    coord_y_t       ev_y;
    logic           window_full;

    centroid_ring_buffer #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .wr_en_i     (valid_in),
        .wr_dat_i    ('{x: x_in, y: y_in}),
        .clr_i       (go_lost),
        .evict_dat_o (evict)
    );

    // C1: window sums, fill count, miss tracking and FSM.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        miss_d      = miss_q;
        go_lost     = 1'b0;
        window_full = (count_q == DEPTH_C);
        ev_x        = window_full ? evict.x : '0;
        ev_y        = window_full ? evict.y : '0;

        // A frame that saw any sample, including one coincident with frame_done, is a hit.
        seen_d = frame_done_in ? 1'b0 : (seen_q | valid_in);
        if (valid_in) begin
            miss_d = '0;
        end else if (frame_done_in && !seen_q && miss_q != TIMEOUT_C) begin
            miss_d = miss_q + 8'd1;
        end

        if (valid_in) begin
            sum_x_d = sum_x_q + SXW'(x_in) - SXW'(ev_x);
            sum_y_d = sum_y_q + SYW'(y_in) - SYW'(ev_y);
            if (!window_full) count_d = count_q + 1'b1;
        end

        case (state_q)
            EMPTY, LOST: if (valid_in) state_d = FILLING;
            FILLING:     if (count_d == DEPTH_C) state_d = LOCKED;
            default:     ;
        endcase

        if (state_q != LOST && miss_d == TIMEOUT_C) begin
            go_lost = 1'b1;
            state_d = LOST;
            count_d = '0;
            sum_x_d = '0;
            sum_y_d = '0;
        end
    end

    // C2: average once the window is full, otherwise pass the newest sample through.
    always_comb begin
        coord_x_t new_x;
        coord_y_t new_y;
        new_x   = (count_q == DEPTH_C) ? coord_x_t'(sum_x_q >> DEPTH_LOG2) : p1_x_q;
        new_y   = (count_q == DEPTH_C) ? coord_y_t'(sum_y_q >> DEPTH_LOG2) : p1_y_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        if (p1_vld_q) begin
`ifdef CENTROID_DEADBAND_EN
            if (((new_x > x_out_q) ? (new_x - x_out_q) : (x_out_q - new_x)) <= coord_x_t'(DEADBAND) &&
                ((new_y > y_out_q) ? (new_y - y_out_q) : (y_out_q - new_y)) <= coord_y_t'(DEADBAND)) begin
                x_out_d = x_out_q;
                y_out_d = y_out_q;
            end else begin
                x_out_d = new_x;
                y_out_d = new_y;
            end
`else
            x_out_d = new_x;
            y_out_d = new_y;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= EMPTY;
            count_q     <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            miss_q      <= '0;
            seen_q      <= 1'b0;
            p1_vld_q    <= 1'b0;
            p1_x_q      <= '0;
            p1_y_q      <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            miss_q      <= miss_d;
            seen_q      <= seen_d;
            p1_vld_q    <= valid_in;
            p1_x_q      <= x_in;
            p1_y_q      <= y_in;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            valid_out_q <= p1_vld_q;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign valid_out  = valid_out_q;
    assign locked_out = (state_q == LOCKED);
    assign lost_out   = (state_q == LOST);

endmodule
